// File: rtl/led_band_controller_core.sv
// Double-buffered LED frame store with per-pixel bit-plane readout to a serial driver,
// plus HPS pass-through for SOUT and a 48-bit HPS-loaded FC shift register.
module led_band_controller_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         w_clk,
  input  logic         write,
  input  logic [9:0]   w_addr_input,
  input  logic [127:0] w_data,
  input  logic         new_frame,
  input  logic [4:0]   row,
  input  logic [6:0]   angle,
  input  logic [1:0]   color,
  input  logic [3:0]   bit_sel,
  input  logic         SCLK,
  input  logic         LAT,
  output logic         SOUT,
  input  logic         hps_override,
  input  logic         hps_SOUT,
  input  logic         hps_fc_clk,
  input  logic         hps_fc_data
);

  logic [127:0] mem_q [2048];

  logic         buf_q, buf_d;
  logic [47:0]  fc_q, fc_d;
  logic         fc_clk_q;
  logic         sout_q, sout_d;

  logic [13:0]  r_addr;
  logic [127:0] rd_word;
  logic [7:0]   rd_byte;
  logic [2:0]   bit_idx;

  // w_clk is the same net as clk; SCLK/LAT only time the external driver.
  logic unused_ok;
  assign unused_ok = ^{w_clk, SCLK, LAT, fc_q[47]};

  // Frame store is not reset; the write uses the pre-toggle bank.
  always_ff @(posedge clk) begin
    if (write) mem_q[{buf_q, w_addr_input}] <= w_data;
  end

  always_comb begin
    buf_d   = buf_q ^ new_frame;
    r_addr  = 14'(color) + 14'(angle) * 14'd3 + 14'(row) * 14'd384;
    rd_word = mem_q[{~buf_q, r_addr[13:4]}];
    rd_byte = rd_word[{r_addr[3:0], 3'b000} +: 8];
    bit_idx = 3'(bit_sel - 4'd1);
    sout_d  = 1'b0;
    if (bit_sel != 4'd0 && bit_sel <= 4'd8) sout_d = rd_byte[bit_idx];
    fc_d    = fc_q;
    if (hps_fc_clk && !fc_clk_q) fc_d = {fc_q[46:0], hps_fc_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q    <= 1'b0;
      fc_q     <= '0;
      fc_clk_q <= 1'b0;
      sout_q   <= 1'b0;
    end else begin
      buf_q    <= buf_d;
      fc_q     <= fc_d;
      fc_clk_q <= hps_fc_clk;
      sout_q   <= sout_d;
    end
  end

  assign SOUT = hps_override ? hps_SOUT : sout_q;

endmodule

// File: tb/tb_led_band_controller_core.sv
// Directed/random bench for led_band_controller_core with a shadow frame-store model.
module tb_led_band_controller_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         write;
  logic [9:0]   w_addr_input;
  logic [127:0] w_data;
  logic         new_frame;
  logic [4:0]   row;
  logic [6:0]   angle;
  logic [1:0]   color;
  logic [3:0]   bit_sel;
  logic         SCLK, LAT;
  logic         SOUT;
  logic         hps_override, hps_SOUT, hps_fc_clk, hps_fc_data;

  int n_vec = 0;
  int n_err = 0;

  logic [127:0] mdl [2048];
  logic         tb_buf;
  logic [47:0]  fc_exp;
  logic [127:0] word0;

  always #5 clk = ~clk;

  led_band_controller_core dut (
    .clk(clk), .rst(rst), .w_clk(clk), .write(write), .w_addr_input(w_addr_input),
    .w_data(w_data), .new_frame(new_frame), .row(row), .angle(angle), .color(color),
    .bit_sel(bit_sel), .SCLK(SCLK), .LAT(LAT), .SOUT(SOUT), .hps_override(hps_override),
    .hps_SOUT(hps_SOUT), .hps_fc_clk(hps_fc_clk), .hps_fc_data(hps_fc_data)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic exp_bit(input logic bank, input int r, input int a, input int c, input int s);
    int ra;
    logic [127:0] w;
    ra = c + 3 * a + 384 * r;
    w  = mdl[(bank ? 1024 : 0) + ra / 16];
    if (s < 1 || s > 8) return 1'b0;
    return w[(ra % 16) * 8 + s - 1];
  endfunction

  task automatic wr(input int addr, input logic [127:0] data);
    write = 1'b1; w_addr_input = 10'(addr); w_data = data;
    mdl[(tb_buf ? 1024 : 0) + addr] = data;
    tick();
    write = 1'b0;
  endtask

  task automatic rd(input string tag, input int r, input int a, input int c, input int s);
    logic e;
    row = 5'(r); angle = 7'(a); color = 2'(c); bit_sel = 4'(s);
    e = exp_bit(~tb_buf, r, a, c, s);
    tick();
    check(tag, 128'(SOUT), 128'(e));
  endtask

  task automatic rd_rand(input string tag, input int n);
    for (int i = 0; i < n; i++)
      rd(tag, $urandom_range(31), $urandom_range(127), $urandom_range(2), $urandom_range(8));
  endtask

  task automatic pulse_frame();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    tb_buf = ~tb_buf;
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; w_addr_input = '0; w_data = '0; new_frame = 1'b0;
    row = '0; angle = '0; color = '0; bit_sel = '0; SCLK = 1'b0; LAT = 1'b0;
    hps_override = 1'b0; hps_SOUT = 1'b0; hps_fc_clk = 1'b0; hps_fc_data = 1'b0;
    tb_buf = 1'b0;
    repeat (3) tick();
    check("rst_sout", 128'(SOUT), 128'd0);
    check("rst_buf", 128'(dut.buf_q), 128'd0);
    check("rst_fc", 128'(dut.fc_q), 128'd0);
    hps_override = 1'b1; hps_SOUT = 1'b1; #1;
    check("rst_ovr", 128'(SOUT), 128'd1);
    hps_override = 1'b0; hps_SOUT = 1'b0;
    @(negedge clk); rst = 1'b0;
    tick();

    // FC load, MSB first, one 1-cycle strobe per bit
    fc_exp = {$urandom, $urandom};
    for (int i = 47; i >= 0; i--) begin
      hps_fc_data = fc_exp[i]; hps_fc_clk = 1'b1; tick();
      hps_fc_clk = 1'b0; tick();
    end
    check("fc_load", 128'(dut.fc_q), 128'(fc_exp));
    // a strobe held high for several cycles shifts only once
    hps_fc_data = 1'b1; hps_fc_clk = 1'b1; repeat (3) tick();
    hps_fc_clk = 1'b0; tick();
    check("fc_hold", 128'(dut.fc_q), 128'({fc_exp[46:0], 1'b1}));

    // bank 0 fill; word 0 has only bit 8 set
    word0 = 128'h0000_0000_0000_0000_0000_0000_0000_0100;
    wr(0, word0);
    for (int a = 1; a < 768; a++) wr(a, rand128());
    // write coinciding with new_frame lands in the old bank
    write = 1'b1; w_addr_input = 10'd768; w_data = 128'hA5A5; new_frame = 1'b1;
    mdl[768] = 128'hA5A5;
    tick();
    write = 1'b0; new_frame = 1'b0; tb_buf = 1'b1;
    check("buf_toggle", 128'(dut.buf_q), 128'd1);
    check("wr_pretoggle", dut.mem_q[768], 128'hA5A5);
    for (int a = 0; a < 768; a++) wr(a, rand128());
    check("bank1_w0", dut.mem_q[1024], mdl[1024]);
    check("bank1_w767", dut.mem_q[1791], mdl[1791]);
    check("bank0_kept", dut.mem_q[0], word0);

    // read bank 0: directed cases
    rd("ex_bit8", 0, 0, 1, 1);
    check("ex_bit8_hand", 128'(SOUT), 128'd1);
    rd("ex_bit0", 0, 0, 0, 1);
    check("ex_bit0_hand", 128'(SOUT), 128'd0);
    rd("bsel0", 0, 0, 1, 0);
    check("bsel0_hand", 128'(SOUT), 128'd0);
    rd("bsel9", 0, 0, 1, 9);
    check("bsel9_hand", 128'(SOUT), 128'd0);
    rd("bsel15", 0, 0, 1, 15);
    rd("max_addr", 31, 127, 2, 8);
    rd("max_addr_b1", 31, 127, 2, 1);
    rd_rand("rd_bank0", 1000);

    pulse_frame();
    rd_rand("rd_bank1", 1000);

    // concurrent write bank 1 / read bank 0
    pulse_frame();
    for (int i = 0; i < 300; i++) begin
      int wa;
      logic e;
      wa = $urandom_range(767);
      write = 1'b1; w_addr_input = 10'(wa); w_data = rand128();
      row = 5'($urandom_range(31)); angle = 7'($urandom_range(127));
      color = 2'($urandom_range(2)); bit_sel = 4'($urandom_range(8));
      e = exp_bit(1'b0, int'(row), int'(angle), int'(color), int'(bit_sel));
      mdl[1024 + wa] = w_data;
      tick();
      check("rw_rd0", 128'(SOUT), 128'(e));
    end
    write = 1'b0;
    pulse_frame();
    rd_rand("rw_rd1", 300);

    // async reset mid-frame
    pulse_frame();
    rd("pre_rst", 0, 0, 1, 1);
    #3 rst = 1'b1; #1;
    check("arst_sout", 128'(SOUT), 128'd0);
    check("arst_buf", 128'(dut.buf_q), 128'd0);
    check("arst_fc", 128'(dut.fc_q), 128'd0);
    @(negedge clk); rst = 1'b0; tb_buf = 1'b0;
    tick();
    rd_rand("post_rst_rd1", 200);

    // HPS override, zero latency
    hps_override = 1'b1;
    for (int i = 0; i < 32; i++) begin
      logic b;
      b = 1'($urandom_range(1));
      hps_SOUT = b; #1;
      check("ovr_comb", 128'(SOUT), 128'(b));
      tick();
      check("ovr_clk", 128'(SOUT), 128'(b));
    end
    hps_override = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
